// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
// Memory-mapped UART transmitter. A store from the core to TX_ADDR pushes
// write_data[7:0] into a small byte FIFO. A serialiser FSM drains the FIFO
// and sends 8N1 frames (start, 8 data bits LSB first, stop) on tx.
//
// Optional build macro: UART_TX_PARITY_EN
//   When defined, an even-parity bit is sent between the last data bit and
//   the stop bit (frame becomes 11 bit times). When undefined, no parity
//   logic is built.
//
// Parameters
//   TX_ADDR       store address that enqueues a byte
//   CLKS_PER_BIT  clock cycles per serial bit (2..65535)
//   FIFO_DEPTH    byte FIFO entries (power of two, >= 2)
//
// Ports
//   clk         single clock, rising edge
//   reset       synchronous active-high reset
//   mem_write   core data-store strobe
//   data_adr    core data address
//   write_data  core store data, bits [7:0] are the payload
//   tx          serial line, idle high, registered
//   busy        FSM not idle or FIFO non-empty
//   fifo_count  current FIFO occupancy
//   drop_cnt    saturating count of bytes lost to overflow
module mmio_uart_tx #(
    parameter logic [31:0] TX_ADDR      = 32'h0000_0100,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mem_write,
    input  logic [31:0]                   data_adr,
    input  logic [31:0]                   write_data,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    drop_cnt
);

    localparam int                PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]       BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_e;

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    state_e             state_q, state_d;
    logic [15:0]        baud_q, baud_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         drop_q, drop_d;
`ifdef UART_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic [7:0]         fifo_mem_q [FIFO_DEPTH];

    logic               push_req;
    logic               push_ok;
    logic               pop;
    logic               fifo_empty;
    logic               baud_done;
    logic [7:0]         head_byte;

    // Only the low byte of the store data is payload.
    logic               unused_hi_bits;
    assign unused_hi_bits = ^write_data[31:8];

    assign push_req   = mem_write && (data_adr == TX_ADDR);
    assign fifo_empty = (count_q == '0);
    assign baud_done  = (baud_q == BAUD_LAST);
    assign head_byte  = fifo_mem_q[rd_ptr_q];

    // ---------------------------------------------------------------
    // Serialiser FSM: next state, counters, shifter, pop request
    // ---------------------------------------------------------------
    always_comb begin : fsm_comb
        state_d   = state_q;
        baud_d    = baud_q + 16'd1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                baud_d    = '0;
                bit_idx_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head_byte;
                    state_d = S_START;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^head_byte;
`endif
                end
            end
            S_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        // Shifter bit 0 is always the bit on the line.
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    // Chain straight into the next frame with no idle gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = head_byte;
                        state_d = S_START;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^head_byte;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase

        // tx is decoded from the *next* state so the registered line
        // changes on the same edge as the FSM.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // ---------------------------------------------------------------
    // FIFO bookkeeping
    // ---------------------------------------------------------------
    always_comb begin : fifo_comb
        // A full FIFO still accepts a byte when the head leaves this cycle.
        push_ok  = push_req && ((count_q != DEPTH_C) || pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (push_req && !push_ok && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            drop_q    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            drop_q    <= drop_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Storage array has no reset; stale contents are unreachable once the
    // pointers are cleared.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            fifo_mem_q[wr_ptr_q] <= write_data[7:0];
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE) || !fifo_empty;
    assign fifo_count = count_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
`timescale 1ns/1ps
module tb_mmio_uart_tx;

    localparam int          CPB     = 4;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] TX_ADDR = 32'h0000_0100;
`ifdef UART_TX_PARITY_EN
    localparam int          FRAME_BITS = 11;
`else
    localparam int          FRAME_BITS = 10;
`endif
    localparam int          FRAME_CYC = FRAME_BITS * CPB;
    localparam int          STOP_FIRST = 2 + FRAME_CYC - CPB;   // first stop cycle of a frame started by a store at cycle 0

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_write = 1'b0;
    logic [31:0] data_adr = '0;
    logic [31:0] write_data = '0;
    logic        tx;
    logic        busy;
    logic [2:0]  fifo_count;
    logic [7:0]  drop_cnt;

    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    bit          mon_en = 1'b1;
    logic [7:0]  sb_q[$];
    int          starts_q[$];

    mmio_uart_tx #(
        .TX_ADDR      (TX_ADDR),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_write  (mem_write),
        .data_adr   (data_adr),
        .write_data (write_data),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Ideal line level for frame bit position idx of byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d);
        mem_write  = 1'b1;
        data_adr   = a;
        write_data = d;
    endtask

    task automatic drive_idle();
        mem_write  = 1'b0;
        data_adr   = '0;
        write_data = '0;
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < max_cyc), 32'd1);
    endtask

    // Serial monitor: captures a whole frame from its first low sample,
    // pops the expected byte from the scoreboard and checks every sample.
    initial begin : monitor
        logic [FRAME_CYC-1:0] samp;
        logic [7:0]           got;
        logic [7:0]           exp_b;
        int                   st;
        int                   bad;
        bit                   aborted;
        forever begin
            @(negedge clk);
            if (mon_en && reset === 1'b0 && tx === 1'b0) begin
                samp    = '0;
                samp[0] = tx;
                st      = cyc;
                aborted = 1'b0;
                for (int j = 1; j < FRAME_CYC; j++) begin
                    @(negedge clk);
                    if (reset !== 1'b0) begin
                        aborted = 1'b1;
                        break;
                    end
                    samp[j] = tx;
                end
                if (!aborted) begin
                    starts_q.push_back(st);
                    got = '0;
                    for (int b = 0; b < 8; b++) got[b] = samp[(b + 1) * CPB + CPB / 2];
                    check("sb_expected_frame", 32'(sb_q.size() != 0), 32'd1);
                    if (sb_q.size() != 0) begin
                        exp_b = sb_q.pop_front();
                        check("frame_byte", 32'(got), 32'(exp_b));
                        bad = 0;
                        for (int j = 0; j < FRAME_CYC; j++)
                            if (samp[j] !== frame_bit(exp_b, j / CPB)) bad++;
                        check("frame_wave_bad_samples", bad, 0);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] b55;
        logic [7:0] b07;
        logic       exp_tx;
        logic       exp_busy;
        int         lows;
        int         busy_hi;

        b55 = 8'h55;
        b07 = 8'h07;

        // ---- reset state ----
        reset = 1'b1;
        drive_idle();
        repeat (3) next_cycle();
        @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // ---- single frame, exact waveform (0x55, upper store bits ignored) ----
        sb_q.push_back(8'h55);
        drive_store(TX_ADDR, 32'hDEAD_BE55);
        for (int k = 0; k < 2 + FRAME_CYC + 2; k++) begin
            @(negedge clk);
            if (k < 2)                       exp_tx = 1'b1;
            else if (k < 6)                  exp_tx = 1'b0;
            else if (k < 38)                 exp_tx = b55[(k - 6) / CPB];
            else if (k < STOP_FIRST)         exp_tx = ^b55;
            else                             exp_tx = 1'b1;
            exp_busy = (k >= 1) && (k < 2 + FRAME_CYC);
            check($sformatf("t1_tx_c%0d", k), 32'(tx), 32'(exp_tx));
            check($sformatf("t1_busy_c%0d", k), 32'(busy), 32'(exp_busy));
            if (k == 1) check("t1_count_c1", 32'(fifo_count), 32'd1);
            if (k == 2) check("t1_count_c2", 32'(fifo_count), 32'd0);
            next_cycle();
            if (k == 0) drive_idle();
        end
        check("t1_sb_drained", sb_q.size(), 0);

        // ---- stores that must be ignored ----
        drive_store(32'h0000_0104, 32'h0000_0041);
        next_cycle();
        drive_store(32'h0000_00FF, 32'h0000_0041);
        next_cycle();
        mem_write  = 1'b0;
        data_adr   = TX_ADDR;
        write_data = 32'h0000_0041;
        next_cycle();
        drive_idle();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("t2_tx_%0d", k), 32'(tx), 32'd1);
            check($sformatf("t2_count_%0d", k), 32'(fifo_count), 32'd0);
            check($sformatf("t2_busy_%0d", k), 32'(busy), 32'd0);
            next_cycle();
        end

        // ---- overflow, push+pop while full, back-to-back frames ----
        starts_q.delete();
        for (int k = 0; k <= FRAME_CYC + 2; k++) begin
            if (k <= 5) begin
                drive_store(TX_ADDR, 32'(k + 1));
                if (k < 5) sb_q.push_back(8'(k + 1));
            end else if (k == FRAME_CYC) begin
                drive_store(TX_ADDR, 32'h0000_0077);     // full, no pop: dropped
            end else if (k == FRAME_CYC + 1) begin
                drive_store(TX_ADDR, 32'h0000_0088);     // full, pop this cycle: accepted
                sb_q.push_back(8'h88);
            end else begin
                drive_idle();
            end
            @(negedge clk);
            if (k == 6) begin
                check("t3_count_full", 32'(fifo_count), 32'd4);
                check("t3_drop_one", 32'(drop_cnt), 32'd1);
            end
            if (k == FRAME_CYC + 1) begin
                check("t3_count_before_pop", 32'(fifo_count), 32'd4);
                check("t3_drop_two", 32'(drop_cnt), 32'd2);
            end
            if (k == FRAME_CYC + 2) begin
                check("t3_count_pushpop_full", 32'(fifo_count), 32'd4);
                check("t3_drop_unchanged", 32'(drop_cnt), 32'd2);
            end
            next_cycle();
        end
        drive_idle();
        wait_idle(6 * FRAME_CYC + 20, "t3_idle_timeout");
        check("t3_sb_drained", sb_q.size(), 0);
        check("t3_frame_count", starts_q.size(), 6);
        for (int i = 1; i < starts_q.size(); i++)
            check($sformatf("t3_gap_%0d", i), starts_q[i] - starts_q[i-1], FRAME_CYC);
        next_cycle();

        // ---- reset mid-frame with bytes queued; store in reset cycle ----
        drive_store(TX_ADDR, 32'h0000_00A5);
        next_cycle();
        drive_store(TX_ADDR, 32'h0000_0011);
        next_cycle();
        drive_store(TX_ADDR, 32'h0000_0022);
        next_cycle();
        drive_idle();
        repeat (11) next_cycle();
        @(negedge clk);
        check("t4_count_queued", 32'(fifo_count), 32'd2);
        check("t4_busy_before", 32'(busy), 32'd1);
        next_cycle();
        reset = 1'b1;
        drive_store(TX_ADDR, 32'h0000_0033);
        next_cycle();
        reset = 1'b0;
        drive_idle();
        @(negedge clk);
        check("t4_tx_after_rst", 32'(tx), 32'd1);
        check("t4_count_after_rst", 32'(fifo_count), 32'd0);
        check("t4_busy_after_rst", 32'(busy), 32'd0);
        check("t4_drop_after_rst", 32'(drop_cnt), 32'd0);
        lows = 0;
        busy_hi = 0;
        for (int k = 0; k < 100; k++) begin
            next_cycle();
            @(negedge clk);
            if (tx !== 1'b1) lows++;
            if (busy !== 1'b0) busy_hi++;
        end
        check("t4_no_frames_tx_low", lows, 0);
        check("t4_no_frames_busy", busy_hi, 0);
        next_cycle();

`ifdef UART_TX_PARITY_EN
        // ---- parity frame for 0x07 ----
        sb_q.push_back(8'h07);
        drive_store(TX_ADDR, 32'h0000_0007);
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            if (k == 37) check("t6_bit7", 32'(tx), 32'(b07[7]));
            if (k == 38) check("t6_parity_first", 32'(tx), 32'd1);
            if (k == 41) check("t6_parity_last", 32'(tx), 32'd1);
            if (k == 42) check("t6_stop", 32'(tx), 32'd1);
            if (k == 45) check("t6_busy_c45", 32'(busy), 32'd1);
            if (k == 46) check("t6_busy_c46", 32'(busy), 32'd0);
            next_cycle();
            if (k == 0) drive_idle();
        end
        check("t6_sb_drained", sb_q.size(), 0);
`endif

        // ---- drop counter saturation ----
        wait_idle(FRAME_CYC * 2, "t5_pre_idle_timeout");
        next_cycle();
        mon_en = 1'b0;
        for (int i = 0; i < 300; i++) begin
            drive_store(TX_ADDR, 32'(i));
            next_cycle();
        end
        drive_idle();
        @(negedge clk);
        check("t5_drop_saturated", 32'(drop_cnt), 32'd255);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("t5_drop_after_rst", 32'(drop_cnt), 32'd0);
        check("t5_count_after_rst", 32'(fifo_count), 32'd0);
        check("t5_tx_after_rst", 32'(tx), 32'd1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
